// File: rtl/tc_sram_pwr_ctrl.sv
// rtl/tc_sram_pwr_ctrl.sv - idle-driven deep-sleep / power-gate sequencer for tc_sram_pwrgate
module tc_sram_pwr_ctrl #(
   parameter int unsigned SleepIdleCycles = 16,
   parameter int unsigned GateIdleCycles  = 256,
   parameter int unsigned SleepWakeCycles = 2,
   parameter int unsigned GateWakeCycles  = 8,
   parameter int unsigned CntWidth        = $clog2(GateIdleCycles + 1)
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       req_i,
   output logic       gnt_o,
   input  logic       sleep_en_i,
   input  logic       gate_en_i,
   input  logic       clear_lost_i,
   output logic       sram_req_o,
   output logic       deepsleep_o,
   output logic       powergate_o,
   output logic       lost_o,
   output logic [1:0] state_o
);

   localparam int unsigned WakeMax   = (GateWakeCycles > SleepWakeCycles) ? GateWakeCycles : SleepWakeCycles;
   localparam int unsigned WakeWidth = (WakeMax > 1) ? $clog2(WakeMax) : 1;

   localparam logic [CntWidth-1:0]  SleepIdleLast = CntWidth'(SleepIdleCycles - 1);
   localparam logic [CntWidth-1:0]  GateIdleLast  = CntWidth'(GateIdleCycles - 1);
   localparam logic [CntWidth-1:0]  GateIdleMax   = CntWidth'(GateIdleCycles);
   localparam logic [WakeWidth-1:0] SleepWakeLast = WakeWidth'(SleepWakeCycles - 1);
   localparam logic [WakeWidth-1:0] GateWakeLast  = WakeWidth'(GateWakeCycles - 1);

   typedef enum logic [1:0] {
      ST_ACTIVE    = 2'd0,
      ST_DEEPSLEEP = 2'd1,
      ST_POWERGATE = 2'd2,
      ST_WAKE      = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [CntWidth-1:0]  idle_q, idle_d;
   logic [WakeWidth-1:0] wake_q, wake_d;
   logic                 lost_q, lost_d;
   logic                 set_lost;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_ACTIVE;
         idle_q  <= '0;
         wake_q  <= '0;
         lost_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idle_q  <= idle_d;
         wake_q  <= wake_d;
         lost_q  <= lost_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wake_d   = wake_q;
      set_lost = 1'b0;

      // Idle counter saturates so a long idle spell cannot wrap back into a match.
      if (req_i) begin
         idle_d = '0;
      end else if (state_q != ST_WAKE && idle_q != GateIdleMax) begin
         idle_d = idle_q + CntWidth'(1);
      end else begin
         idle_d = idle_q;
      end

      unique case (state_q)
         ST_ACTIVE: begin
            if (sleep_en_i && !req_i && idle_q == SleepIdleLast) begin
               state_d = ST_DEEPSLEEP;
            end
         end
         ST_DEEPSLEEP: begin
            if (req_i || !sleep_en_i) begin
               state_d = ST_WAKE;
               wake_d  = SleepWakeLast;
            end else if (gate_en_i && idle_q == GateIdleLast) begin
               state_d  = ST_POWERGATE;
               set_lost = 1'b1;
            end
         end
         ST_POWERGATE: begin
            if (req_i || !gate_en_i || !sleep_en_i) begin
               state_d = ST_WAKE;
               wake_d  = GateWakeLast;
            end
         end
         ST_WAKE: begin
            if (wake_q == '0) begin
               state_d = ST_ACTIVE;
               idle_d  = '0;
            end else begin
               wake_d = wake_q - WakeWidth'(1);
            end
         end
         default: state_d = ST_ACTIVE;
      endcase

      if (set_lost) begin
         lost_d = 1'b1;
      end else if (clear_lost_i) begin
         lost_d = 1'b0;
      end else begin
         lost_d = lost_q;
      end
   end

   assign gnt_o       = (state_q == ST_ACTIVE);
   assign sram_req_o  = req_i & gnt_o;
   assign deepsleep_o = (state_q == ST_DEEPSLEEP) || (state_q == ST_POWERGATE);
   assign powergate_o = (state_q == ST_POWERGATE);
   assign lost_o      = lost_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_tc_sram_pwr_ctrl.sv
// tb/tb_tc_sram_pwr_ctrl.sv - scoreboard bench for tc_sram_pwr_ctrl against a cycle-count model
module tb_tc_sram_pwr_ctrl;

   localparam int SLEEP_IDLE = 16;
   localparam int GATE_IDLE  = 256;
   localparam int SLEEP_WAKE = 2;
   localparam int GATE_WAKE  = 8;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       req_i;
   logic       gnt_o;
   logic       sleep_en_i;
   logic       gate_en_i;
   logic       clear_lost_i;
   logic       sram_req_o;
   logic       deepsleep_o;
   logic       powergate_o;
   logic       lost_o;
   logic [1:0] state_o;

   tc_sram_pwr_ctrl dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_i        (req_i),
      .gnt_o        (gnt_o),
      .sleep_en_i   (sleep_en_i),
      .gate_en_i    (gate_en_i),
      .clear_lost_i (clear_lost_i),
      .sram_req_o   (sram_req_o),
      .deepsleep_o  (deepsleep_o),
      .powergate_o  (powergate_o),
      .lost_o       (lost_o),
      .state_o      (state_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic       gnt;
      logic       sram_req;
      logic       ds;
      logic       pg;
      logic       lost;
      logic [1:0] st;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   // Model: mode is the reported state number, idle is an unbounded count of
   // quiet cycles, wake_left is how many WAKE cycles remain including this one.
   int m_mode, m_idle, m_wake_left;
   bit m_lost;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
   endtask

   task automatic model_advance(input logic r, input logic se, input logic ge, input logic clr);
      bit enter_pg;
      int idle_now;
      enter_pg = 0;
      if (m_mode == 3) begin
         m_wake_left--;
         if (m_wake_left == 0) begin
            m_mode = 0;
            m_idle = 0;
         end
      end else begin
         idle_now = m_idle;
         m_idle   = r ? 0 : m_idle + 1;
         case (m_mode)
            0: if (se && !r && idle_now == SLEEP_IDLE - 1) m_mode = 1;
            1: begin
               if (r || !se) begin
                  m_mode = 3;
                  m_wake_left = SLEEP_WAKE;
               end else if (ge && idle_now == GATE_IDLE - 1) begin
                  m_mode = 2;
                  enter_pg = 1;
               end
            end
            2: if (r || !ge || !se) begin
               m_mode = 3;
               m_wake_left = GATE_WAKE;
            end
            default: ;
         endcase
      end
      if (enter_pg) m_lost = 1;
      else if (clr) m_lost = 0;
   endtask

   task automatic drive(input logic r, input logic se, input logic ge, input logic clr, input logic rst);
      exp_t e;
      @(posedge clk_i);
      #1;
      req_i = r; sleep_en_i = se; gate_en_i = ge; clear_lost_i = clr; rst_ni = rst;
      if (!rst) begin
         m_mode = 0; m_idle = 0; m_wake_left = 0; m_lost = 0;
      end
      e.gnt      = (m_mode == 0);
      e.sram_req = r && (m_mode == 0);
      e.ds       = (m_mode == 1) || (m_mode == 2);
      e.pg       = (m_mode == 2);
      e.lost     = m_lost;
      e.st       = m_mode[1:0];
      exp_q.push_back(e);
      if (rst) model_advance(r, se, ge, clr);
   endtask

   always @(negedge clk_i) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("gnt_o",       int'(gnt_o),       int'(e.gnt));
         chk("sram_req_o",  int'(sram_req_o),  int'(e.sram_req));
         chk("deepsleep_o", int'(deepsleep_o), int'(e.ds));
         chk("powergate_o", int'(powergate_o), int'(e.pg));
         chk("lost_o",      int'(lost_o),      int'(e.lost));
         chk("state_o",     int'(state_o),     int'(e.st));
      end
   end

   initial begin
      #3_000_000;
      n_total++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      int len;
      int kind;
      logic se, ge;
      req_i = 0; sleep_en_i = 1; gate_en_i = 0; clear_lost_i = 0; rst_ni = 0;
      m_mode = 0; m_idle = 0; m_wake_left = 0; m_lost = 0;

      repeat (3) drive(0, 1, 0, 0, 0);
      // sleep entry, then sleep wake with req held
      repeat (40) drive(0, 1, 0, 0, 1);
      repeat (5)  drive(1, 1, 0, 0, 1);
      // gate entry coinciding with a clear pulse, then gate wake and lost clear
      repeat (255) drive(0, 1, 1, 0, 1);
      drive(0, 1, 1, 1, 1);
      repeat (40) drive(0, 1, 1, 0, 1);
      repeat (12) drive(1, 1, 1, 0, 1);
      repeat (3)  drive(0, 1, 1, 0, 1);
      drive(0, 1, 1, 1, 1);
      repeat (3)  drive(0, 1, 1, 0, 1);
      // enable drop out of power gate
      repeat (270) drive(0, 1, 1, 0, 1);
      repeat (40)  drive(0, 1, 0, 0, 1);
      // periodic requests keep the block awake
      for (int i = 0; i < 300; i++) drive(i % 15 == 0, 1, 1, 0, 1);
      // reset during wake
      repeat (20) drive(0, 1, 0, 0, 1);
      repeat (2)  drive(1, 1, 0, 0, 1);
      repeat (3)  drive(1, 1, 0, 0, 0);
      repeat (5)  drive(1, 1, 0, 0, 1);

      for (int p = 0; p < 80; p++) begin
         kind = $urandom_range(0, 4);
         se = ($urandom_range(0, 7) != 0);
         ge = ($urandom_range(0, 3) != 0);
         case (kind)
            0: begin
               len = $urandom_range(230, 300);
               repeat (len) drive(0, se, ge, $urandom_range(0, 63) == 0, 1);
            end
            1: begin
               len = $urandom_range(10, 60);
               for (int i = 0; i < len; i++) begin
                  if ($urandom_range(0, 19) == 0) se = ~se;
                  if ($urandom_range(0, 19) == 0) ge = ~ge;
                  drive($urandom_range(0, 3) == 0, se, ge, $urandom_range(0, 15) == 0, 1);
               end
            end
            2: begin
               len = $urandom_range(1, 4);
               repeat (len) drive($urandom_range(0, 1) == 1, se, ge, 0, 0);
            end
            3: begin
               len = $urandom_range(20, 40);
               repeat (len) drive(0, 1, ge, $urandom_range(0, 3) == 0, 1);
            end
            default: begin
               len = $urandom_range(1, 12);
               repeat (len) drive(1, se, ge, 0, 1);
            end
         endcase
      end

      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
